// File: rtl/pipo_univ_shift.sv
// Parametrised PIPO register with parallel load and a multi-cycle shift/rotate
// engine driven by a start/busy/done handshake; serial ports allow cascading.
module pipo_univ_shift #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pi,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] po,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_SHL = 3'b000,
    OP_SHR = 3'b001,
    OP_ROL = 3'b010,
    OP_ROR = 3'b011,
    OP_ASR = 3'b100
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] remaining;
  logic             mode_valid;

  // Codes above ASR are reserved; a start carrying one is simply dropped.
  assign mode_valid = (mode <= OP_ASR);

  assign sout_l = po[WIDTH-1];
  assign sout_r = po[0];

  function automatic logic [WIDTH-1:0] shift_once(
    input logic [WIDTH-1:0] v,
    input op_e              op,
    input logic             sl,
    input logic             sr
  );
    case (op)
      OP_SHL:  return {v[WIDTH-2:0], sr};
      OP_SHR:  return {sl, v[WIDTH-1:1]};
      OP_ROL:  return {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  return {v[0], v[WIDTH-1:1]};
      OP_ASR:  return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  // NOTE: asynchronous reset plus non-blocking assignments throughout, so every
  // register samples pre-edge values and an abort needs no clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= OP_SHL;
      remaining <= '0;
      po        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            po <= pi;
          end else if (start && mode_valid) begin
            op_q      <= op_e'(mode);
            remaining <= count;
            if (count != '0) begin
              state <= S_SHIFT;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          // Serial inputs are taken live at each shift edge, not at start.
          po        <= shift_once(po, op_q, sin_l, sin_r);
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_univ_shift.sv
// Self-checking bench for pipo_univ_shift: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_pipo_univ_shift;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          load;
  logic [W-1:0]  pi;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] count;
  logic          sin_l;
  logic          sin_r;
  logic [W-1:0]  po;
  logic          sout_l;
  logic          sout_r;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_po;

  pipo_univ_shift #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .pi     (pi),
    .start  (start),
    .mode   (mode),
    .count  (count),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .po     (po),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: one shift step expressed with integer arithmetic on the value.
  function automatic int model_shift(input int v, input int m, input int sl, input int sr);
    int top;
    int full;
    top  = 1 << (W - 1);
    full = 1 << W;
    case (m)
      0:       return (v * 2 + sr) % full;
      1:       return v / 2 + sl * top;
      2:       return (v * 2) % full + v / top;
      3:       return v / 2 + (v % 2) * top;
      4:       return v / 2 + ((v >= top) ? top : 0);
      default: return v;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load  = 1'b0;
    start = 1'b0;
    pi    = '0;
    mode  = 3'b000;
    count = '0;
  endtask

  task automatic do_load(input logic [W-1:0] val, input string tag);
    load = 1'b1;
    pi   = val;
    step();
    load = 1'b0;
    exp_po = val;
    n_cmp++;
    if (po !== exp_po) begin
      n_err++;
      $display("FAIL %s load: po got %b want %b", tag, po, exp_po);
    end
  endtask

  // Launches one operation and follows it cycle by cycle against the model.
  task automatic run_op(input int m, input int n, input bit rand_sin,
                        input bit sl_fix, input bit sr_fix, input bit noise,
                        input bit tail, input string tag);
    int v;
    int r;
    bit sl;
    bit sr;
    start = 1'b1;
    mode  = 3'(m);
    count = CW'(n);
    step();
    start = 1'b0;
    v = int'(exp_po);
    if (n == 0) begin
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || po !== exp_po) begin
        n_err++;
        $display("FAIL %s zero-count: done=%b busy=%b po=%b want done=1 busy=0 po=%b",
                 tag, done, busy, po, exp_po);
      end
    end else begin
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || po !== exp_po) begin
        n_err++;
        $display("FAIL %s accept: busy=%b done=%b po=%b want busy=1 done=0 po=%b",
                 tag, busy, done, po, exp_po);
      end
      for (int k = 1; k <= n; k++) begin
        sl = rand_sin ? 1'($urandom) : sl_fix;
        sr = rand_sin ? 1'($urandom) : sr_fix;
        sin_l = sl;
        sin_r = sr;
        if (noise) begin
          load  = 1'b1;
          pi    = W'($urandom);
          start = 1'b1;
          mode  = 3'($urandom_range(0, 4));
          count = CW'($urandom);
        end
        step();
        r = model_shift(v, m, int'(sl), int'(sr));
        v = r;
        exp_po = r[W-1:0];
        n_cmp++;
        if (po !== exp_po || sout_l !== exp_po[W-1] || sout_r !== exp_po[0]) begin
          n_err++;
          $display("FAIL %s shift %0d: po=%b sout_l=%b sout_r=%b want po=%b",
                   tag, k, po, sout_l, sout_r, exp_po);
        end
        n_cmp++;
        if (busy !== (k < n) || done !== (k == n)) begin
          n_err++;
          $display("FAIL %s handshake %0d: busy=%b done=%b want busy=%b done=%b",
                   tag, k, busy, done, k < n, k == n);
        end
      end
      idle_inputs();
    end
    if (tail) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || po !== exp_po) begin
        n_err++;
        $display("FAIL %s tail: done=%b busy=%b po=%b want done=0 busy=0 po=%b",
                 tag, done, busy, po, exp_po);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (po !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: po=%b busy=%b done=%b want 0000/0/0", po, busy, done);
    end
    step();
    reset = 1'b1;
    do_load(4'b1100, "reset_load");
  endtask

  task automatic test_shl();
    do_load(4'b1100, "shl");
    run_op(0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "shl");
    n_cmp++;
    if (po !== 4'b0011) begin
      n_err++;
      $display("FAIL shl final: po=%b want 0011", po);
    end
  endtask

  task automatic test_ror_wrap();
    do_load(4'b1010, "ror");
    run_op(3, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "ror");
    n_cmp++;
    if (po !== 4'b0101) begin
      n_err++;
      $display("FAIL ror final: po=%b want 0101", po);
    end
  endtask

  task automatic test_asr();
    do_load(4'b1001, "asr");
    run_op(4, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "asr");
    n_cmp++;
    if (po !== 4'b1111) begin
      n_err++;
      $display("FAIL asr final: po=%b want 1111", po);
    end
  endtask

  task automatic test_count_zero();
    do_load(4'b0110, "cnt0");
    run_op(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "cnt0");
  endtask

  task automatic test_load_priority();
    do_load(4'b0110, "prio");
    load  = 1'b1;
    pi    = 4'b0101;
    start = 1'b1;
    mode  = 3'b000;
    count = 3'd3;
    step();
    idle_inputs();
    exp_po = 4'b0101;
    n_cmp++;
    if (po !== exp_po || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL load_prio: po=%b busy=%b done=%b want 0101/0/0", po, busy, done);
    end
    step();
    n_cmp++;
    if (po !== exp_po || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL load_prio next: po=%b busy=%b done=%b want 0101/0/0", po, busy, done);
    end
  endtask

  task automatic test_ignored_while_busy();
    do_load(4'b0110, "busy_ign");
    run_op(2, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "busy_ign");
  endtask

  task automatic test_reserved();
    do_load(4'b0110, "rsvd");
    for (int m = 5; m <= 7; m++) begin
      start = 1'b1;
      mode  = 3'(m);
      count = 3'd3;
      step();
      idle_inputs();
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || po !== exp_po) begin
          n_err++;
          $display("FAIL reserved mode %0d cyc %0d: busy=%b done=%b po=%b want 0/0/%b",
                   m, c, busy, done, po, exp_po);
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen_done;
    do_load(4'b0001, "rst_mid");
    start = 1'b1;
    mode  = 3'b010;
    count = 3'd4;
    step();
    idle_inputs();
    step();
    step();
    n_cmp++;
    if (po !== 4'b0100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid before: po=%b busy=%b want 0100/1", po, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (po !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid abort: po=%b busy=%b done=%b want 0000/0/0", po, busy, done);
    end
    step();
    reset = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0 || po !== '0) begin
      n_err++;
      $display("FAIL rst_mid after: stray busy/done=%b po=%b want 0/0000", seen_done, po);
    end
    do_load(4'b1011, "rst_mid_reload");
  endtask

  task automatic test_back_to_back();
    do_load(W'($urandom), "b2b");
    for (int i = 0; i < 6; i++)
      run_op($urandom_range(0, 4), $urandom_range(1, 7), 1'b1, 1'b0, 1'b0,
             1'b0, (i == 5), "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_load(W'($urandom), "rand");
      run_op($urandom_range(0, 4), $urandom_range(0, 7), 1'b1, 1'b0, 1'b0,
             1'($urandom), 1'b1, "rand");
    end
  endtask

  initial begin
    reset = 1'b0;
    sin_l = 1'b0;
    sin_r = 1'b0;
    exp_po = '0;
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    test_reset();
    test_shl();
    test_ror_wrap();
    test_asr();
    test_count_zero();
    test_load_priority();
    test_ignored_while_busy();
    test_reserved();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipo_univ_shift.md
Name: pipo_univ_shift

Overview:
Parametrised successor to the team's 4-bit PIPO register. Keeps parallel load and parallel output, and adds a multi-cycle shift/rotate engine. A start pulse launches a shift of `count` positions, one position per clock, under a busy/done handshake. Serial in/out on both ends allows cascading. The block is a general-purpose data-path register for serialisers, bit-manipulation and alignment logic.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 3, width of the shift-count input; maximum count is 2^CNT_W-1

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
load  in  1  parallel-load request
pi  in  WIDTH  parallel input data
start  in  1  launch a shift operation
mode  in  3  operation select, sampled on start
count  in  CNT_W  number of single-position shifts, sampled on start
sin_l  in  1  serial fill bit entering at the MSB (SHR)
sin_r  in  1  serial fill bit entering at the LSB (SHL)
po  out  WIDTH  registered parallel output
sout_l  out  1  po[WIDTH-1], combinational
sout_r  out  1  po[0], combinational
busy  out  1  high while a shift operation is in progress
done  out  1  one-cycle pulse when an operation completes

Behaviour:
- Reset (reset=0, asynchronous, any time): po=0, busy=0, done=0, remaining=0, latched mode=0. Reset has priority over everything else.
- Reset during an operation: the operation aborts immediately and no done pulse is issued.
- Modes:
  - 000 SHL: po <= {po[W-2:0], sin_r}
  - 001 SHR: po <= {sin_l, po[W-1:1]}
  - 010 ROL, 011 ROR: rotate one position
  - 100 ASR: MSB replicated
  - 101-111 reserved: start is ignored, with no busy and no done.
- Serial inputs are sampled live on every shift edge; they are not latched at start.
- Two states, IDLE and SHIFT.
- IDLE:
  - load=1: po <= pi at the edge. load has priority over start in the same cycle; that start is dropped.
  - start=1, load=0, valid mode: latch mode, remaining <= count.
    - count != 0: go to SHIFT, busy=1 from the next cycle. No shift happens on the accept edge.
    - count == 0: stay in IDLE; done=1 for the next cycle; po unchanged.
- SHIFT:
  - Each rising edge performs one shift and decrements remaining.
  - On the edge that performs the final shift (remaining==1): busy <= 0, done <= 1 for exactly one cycle, return to IDLE.
  - So count=N gives busy high for exactly N cycles; the final po is valid in the same cycle that done is high.
  - load and start are ignored while busy; they are not queued.
- done is a registered pulse, never high for two consecutive cycles. A new start may be accepted in the cycle done is high, since busy=0.
- count is not limited to WIDTH. Rotates wrap naturally. Shifts beyond WIDTH fill entirely with serial or sign bits.
- remaining is CNT_W bits wide and never underflows.

Test Plan:
1. Reset and load:
   - Stimulus: reset=0 mid-cycle.
   - Response: po=0000, busy=0, done=0 asynchronously.
   - Stimulus: release reset, load=1, pi=1100.
   - Response: po=1100 after the next edge.
2. SHL with serial fill:
   - Stimulus: po=1100, start with mode=000, count=2, sin_r=1.
   - Response: po goes 1001 then 0011; busy high exactly 2 cycles; done pulses in the cycle po=0011.
3. ROR wrap-around:
   - Stimulus: po=1010, start with mode=011, count=5.
   - Response: po=1010 after 4 shifts and 0101 after the 5th; busy high 5 cycles; one done pulse.
4. ASR sign fill:
   - Stimulus: po=1001, start with mode=100, count=3.
   - Response: po goes 1100, 1110, 1111.
5. Edge cases, starting from po=0110:
   - start with count=0: done high for one cycle, busy stays 0, po stays 0110.
   - load=1, pi=0101 together with start: po=0101 and no operation launched.
   - start or load while busy: ignored.
   - start with mode=110: no busy, no done.
6. Reset mid-operation:
   - Stimulus: ROL count=4 from po=0001; assert reset after 2 shifts (po=0100).
   - Response: po=0000 and busy=0 immediately; done never pulses; after release the block accepts a new load.
